// File: rtl/mem_wb_unit_if.sv
// Data bus between the memory/write-back stage (master) and the data memory (slave).
// One transaction is outstanding at a time. bus_rdata is valid in the same cycle as bus_ack.
interface mem_wb_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_wb_unit.sv
// Memory-access / write-back stage: single outstanding req/ack bus access with lane steering,
// load extension and a bus timeout, plus the register-file write port for plain ALU results.
module mem_wb_unit #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic         clk,
  input  logic         rst,
  mem_wb_unit_if.master bus,
  input  logic         add_res_val,
  input  logic [31:0]  add_res,
  input  logic [4:0]   rd_mem,
  input  logic         dram_as,
  input  logic         dram_we,
  input  logic [31:0]  dram_addr,
  input  logic [31:0]  store_wdat,
  input  logic [2:0]   i_type_load_funct3_wb,
  input  logic [2:0]   s_type_store_funct3_wb,
  output logic         stall,
  output logic         rd_we,
  output logic [4:0]   rd_waddr,
  output logic [31:0]  rd_wdata,
  output logic         bus_fault,
  output logic [31:0]  fault_addr,
  output logic         ill_op
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t           r_state;
  logic             r_stall;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [31:0]      r_bus_wdata;
  logic [3:0]       r_bus_be;
  logic [31:0]      r_byte_addr;
  logic [1:0]       r_off;
  logic [2:0]       r_f3;
  logic [4:0]       r_rd;
  logic             r_is_load;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_we;
  logic [4:0]       r_rd_waddr;
  logic [31:0]      r_rd_wdata;
  logic             r_bus_fault;
  logic [31:0]      r_fault_addr;
  logic             r_ill_op;

  logic [1:0]       w_off;
  logic             w_store_ok;
  logic             w_load_ok;
  logic [3:0]       w_st_be;
  logic [31:0]      w_st_wdata;
  logic [7:0]       w_ld_byte;
  logic [15:0]      w_ld_half;
  logic [31:0]      w_ld_fmt;

  assign w_off      = dram_addr[1:0];
  assign w_store_ok = (s_type_store_funct3_wb <= 3'd2);
  assign w_load_ok  = !(i_type_load_funct3_wb == 3'd3 ||
                        i_type_load_funct3_wb == 3'd6 ||
                        i_type_load_funct3_wb == 3'd7);

  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = store_wdat;
    case (s_type_store_funct3_wb)
      3'd0: begin
        w_st_be    = 4'b0001 << w_off;
        w_st_wdata = {4{store_wdat[7:0]}};
      end
      3'd1: begin
        w_st_be    = 4'b0011 << w_off;
        w_st_wdata = {2{store_wdat[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = store_wdat;
      end
    endcase
  end

  // Read data arrives unaligned on the full word; pick the lane from the latched offset.
  always_comb begin
    w_ld_byte = bus.bus_rdata[{r_off, 3'b000} +: 8];
    w_ld_half = r_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (r_f3)
      3'd0:    w_ld_fmt = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'd4:    w_ld_fmt = {24'h000000, w_ld_byte};
      3'd1:    w_ld_fmt = {{16{w_ld_half[15]}}, w_ld_half};
      3'd5:    w_ld_fmt = {16'h0000, w_ld_half};
      default: w_ld_fmt = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_stall      <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_be     <= '0;
      r_byte_addr  <= '0;
      r_off        <= '0;
      r_f3         <= '0;
      r_rd         <= '0;
      r_is_load    <= 1'b0;
      r_cnt        <= '0;
      r_rd_we      <= 1'b0;
      r_rd_waddr   <= '0;
      r_rd_wdata   <= '0;
      r_bus_fault  <= 1'b0;
      r_fault_addr <= '0;
      r_ill_op     <= 1'b0;
    end else begin
      r_rd_we     <= 1'b0;
      r_bus_fault <= 1'b0;
      r_ill_op    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Memory requests outrank add_res_val; a store also outranks a simultaneous load.
          if (dram_we) begin
            r_ill_op <= dram_as || !w_store_ok;
            if (w_store_ok) begin
              r_state     <= ST_BUSY;
              r_stall     <= 1'b1;
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b1;
              r_bus_addr  <= {dram_addr[31:2], 2'b00};
              r_bus_be    <= w_st_be;
              r_bus_wdata <= w_st_wdata;
              r_byte_addr <= dram_addr;
              r_off       <= w_off;
              r_f3        <= s_type_store_funct3_wb;
              r_rd        <= rd_mem;
              r_is_load   <= 1'b0;
              r_cnt       <= '0;
            end
          end else if (dram_as) begin
            if (w_load_ok) begin
              r_state     <= ST_BUSY;
              r_stall     <= 1'b1;
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b0;
              r_bus_addr  <= {dram_addr[31:2], 2'b00};
              r_bus_be    <= 4'b1111;
              r_byte_addr <= dram_addr;
              r_off       <= w_off;
              r_f3        <= i_type_load_funct3_wb;
              r_rd        <= rd_mem;
              r_is_load   <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_ill_op <= 1'b1;
            end
          end else if (add_res_val) begin
            r_rd_we    <= (rd_mem != 5'd0);
            r_rd_waddr <= rd_mem;
            r_rd_wdata <= add_res;
          end
        end
        ST_BUSY: begin
          // An ack on the expiry cycle is checked first so it completes normally.
          if (bus.bus_ack) begin
            r_state   <= ST_IDLE;
            r_stall   <= 1'b0;
            r_bus_req <= 1'b0;
            if (r_is_load) begin
              r_rd_we    <= (r_rd != 5'd0);
              r_rd_waddr <= r_rd;
              r_rd_wdata <= w_ld_fmt;
            end
          end else if (TIMEOUT_CYC > 0 && r_cnt == LP_LAST) begin
            r_state      <= ST_IDLE;
            r_stall      <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_fault  <= 1'b1;
            r_fault_addr <= r_byte_addr;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_stall   <= 1'b0;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_be    = r_bus_be;
  assign stall         = r_stall;
  assign rd_we         = r_rd_we;
  assign rd_waddr      = r_rd_waddr;
  assign rd_wdata      = r_rd_wdata;
  assign bus_fault     = r_bus_fault;
  assign fault_addr    = r_fault_addr;
  assign ill_op        = r_ill_op;

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Memory-access / write-back stage directly downstream of the execute ALU.
- Consumes the registered ALU results (arithmetic result, DRAM address, store data, access strobes, funct3).
- Runs a single outstanding req/ack transaction on the data bus, with byte-lane steering, load sign/zero extension and a bus timeout.
- Produces the register-file write port and a stall to upstream.

Parameters:
- TIMEOUT_CYC, 16: cycles in BUSY without ack before abort; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- add_res_val  in  1  ALU result valid (non-memory write-back)
- add_res  in  32  ALU result
- rd_mem  in  5  destination register of the instruction now in this stage
- dram_as  in  1  load request
- dram_we  in  1  store request
- dram_addr  in  32  byte address
- store_wdat  in  32  store data, LSB-aligned
- i_type_load_funct3_wb  in  3  load funct3
- s_type_store_funct3_wb  in  3  store funct3
- stall  out  1  upstream must hold while high
- bus_req  out  1  data bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated write data
- bus_be  out  4  byte enables
- bus_ack  in  1  transaction complete; rdata valid in the same cycle
- bus_rdata  in  32  read word
- rd_we  out  1  register-file write enable
- rd_waddr  out  5  register-file write address
- rd_wdata  out  32  register-file write data
- bus_fault  out  1  one-cycle pulse on timeout
- fault_addr  out  32  byte address of the faulted access
- ill_op  out  1  one-cycle pulse on illegal funct3

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-transaction drops bus_req next edge; no write-back, no fault.
- FSM states: IDLE, BUSY. stall = (state==BUSY), registered.
- IDLE, dram_as|dram_we sampled at edge T:
  - Latch addr, lane, funct3, rd_mem, data.
  - Go to BUSY. bus_req/bus_we/bus_addr/bus_be/bus_wdata are valid from T+1 and stable until ack.
  - dram_as and dram_we both high: the store wins, the load is ignored, ill_op pulses.
- Store lanes, off = addr[1:0]:
  - funct3 0 (sb): be = 4'b0001<<off, wdata = {4{d[7:0]}}.
  - funct3 1 (sh): be = 4'b0011<<off, wdata = {2{d[15:0]}}.
  - funct3 2 (sw): be = 4'b1111, wdata = d.
- Loads: be = 4'b1111.
- Illegal funct3 (load 3/6/7, store >2): no bus access, stay IDLE, ill_op pulses at T+1, no write-back.
- Misaligned accesses are already filtered upstream. Alignment is not rechecked here; lanes are computed from addr[1:0] regardless.
- BUSY, bus_ack sampled at edge A:
  - bus_req deasserts at A+1; return to IDLE at A+1.
  - Load: rd_we=1 at A+1 for one cycle; rd_wdata = formatted bus_rdata.
  - Store: no write-back.
- Load formatting:
  - lb: sign-extend byte[off]; lbu: zero-extend byte[off].
  - lh: sign-extend half[off[1]]; lhu: zero-extend half[off[1]].
  - lw: the full word.
- Non-memory write-back: add_res_val in IDLE at edge T → rd_we=1 at T+1, rd_wdata = add_res, rd_waddr = rd_mem.
- add_res_val together with a memory request: the memory request takes precedence and add_res_val is ignored.
- Inputs sampled while BUSY are ignored (upstream is stalled).
- rd_waddr == 0: rd_we forced to 0 and rd_wdata still driven.
- Timeout (TIMEOUT_CYC > 0):
  - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it equals TIMEOUT_CYC-1 with no ack: bus_req drops next edge, bus_fault pulses one cycle, fault_addr = latched byte address, no write-back, return to IDLE.
  - Ack in the same cycle as expiry: ack wins, no fault.
- A new request may be accepted in the cycle stall falls (back-to-back accesses, one idle bus cycle between).

Test Plan:
- sb, addr=0x1003, store_wdat=0x000000AB → bus_be=4'b1000, bus_wdata=0xABABABAB, bus_addr=0x1000, bus_we=1; on ack: no rd_we, stall low next cycle.
- lb, addr=0x2002, rd=5, ack after 3 wait cycles with bus_rdata=0x12F03456 → stall high 4 cycles, rd_we=1 with rd_wdata=0xFFFFFFF0 to x5; lbu with the same data → 0x000000F0.
- lh/lhu, addr=0x2002, rdata=0x8001_0000 → 0xFFFF8001 and 0x00008001; lw → 0x80010000.
- add_res_val=1, add_res=0xDEADBEEF, rd=7 → next cycle rd_we=1, rd_waddr=7; repeat with rd=0 → rd_we=0.
- Load with no ack and TIMEOUT_CYC=16 → bus_req high 16 cycles, then bus_fault pulse with fault_addr = the issued address, no rd_we, stall cleared; ack exactly on the expiry cycle → normal completion, no fault.
- Load funct3=3 → no bus_req, ill_op pulse; assert rst during BUSY → bus_req=0 and stall=0 after the edge, no rd_we.
